// File: rtl/mux_scan_seq_if.sv
// Bus bundle between mux_scan_seq and its neighbours.
// It carries the scan control, the 8:1 mux select/sample pair and the sample output handshake.
interface mux_scan_seq_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             abort;
  logic [7:0]       chan_mask;
  logic [WIDTH-1:0] mux_y;
  logic             s2;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_chan;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  start, abort, chan_mask, mux_y, out_ready,
    output s2, s1, s0, out_data, out_chan, out_valid, busy, done
  );

  modport master (
    output start, abort, chan_mask, mux_y, out_ready,
    input  s2, s1, s0, out_data, out_chan, out_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Channel scanner driving the select lines of an 8:1 mux and streaming the samples out.
// Optional macro MUX_SCAN_LOOP_EN: wrap to the lowest enabled channel forever instead of one pass.
module mux_scan_seq #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_seq_if.slave bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       chan_q, chan_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [7:0]       higher;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Enabled channels strictly above the one currently selected.
  assign higher = mask_q & (8'hFE << sel_q);

  // Output handshake: a sample transfers at a rising edge where out_valid and out_ready are
  // both high; while out_valid is high and out_ready low, data, channel and select hold still.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    chan_d  = chan_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          mask_d = bus.chan_mask;
          if (bus.chan_mask != 8'h00) begin
            state_d = SEL;
            sel_d   = lowest_set(bus.chan_mask);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEL: begin
        if (bus.abort) begin
          state_d = IDLE;
          sel_d   = 3'd0;
          valid_d = 1'b0;
        end else begin
          state_d = HOLD;
          data_d  = bus.mux_y;
          chan_d  = sel_q;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
          sel_d   = 3'd0;
          valid_d = 1'b0;
        end else if (bus.out_ready) begin
          valid_d = 1'b0;
          if (higher != 8'h00) begin
            state_d = SEL;
            sel_d   = lowest_set(higher);
          end else begin
`ifdef MUX_SCAN_LOOP_EN
            state_d = SEL;
            sel_d   = lowest_set(mask_q);
`else
            state_d = IDLE;
            sel_d   = 3'd0;
            done_d  = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 8'h00;
      sel_q   <= 3'd0;
      chan_q  <= 3'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.s2        = sel_q[2];
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq driving a behavioural 8:1 mux whose inputs a..h are 0..7.
// Table of scan vectors plus hand sequences for abort, async reset and the loop build.
module tb_mux_scan_seq;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mux_scan_seq_if #(.WIDTH(3)) bus ();

  mux_scan_seq #(.WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Downstream 8:1 mux, inputs a..h tied to their own index.
  logic [2:0] mux_a, mux_b, mux_c, mux_d, mux_e, mux_f, mux_g, mux_h;
  assign mux_a = 3'd0; assign mux_b = 3'd1; assign mux_c = 3'd2; assign mux_d = 3'd3;
  assign mux_e = 3'd4; assign mux_f = 3'd5; assign mux_g = 3'd6; assign mux_h = 3'd7;

  always_comb begin
    case ({bus.s2, bus.s1, bus.s0})
      3'd0:    bus.mux_y = mux_a;
      3'd1:    bus.mux_y = mux_b;
      3'd2:    bus.mux_y = mux_c;
      3'd3:    bus.mux_y = mux_d;
      3'd4:    bus.mux_y = mux_e;
      3'd5:    bus.mux_y = mux_f;
      3'd6:    bus.mux_y = mux_g;
      default: bus.mux_y = mux_h;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0]  mask;
    int          stall;
    logic        mid_start;
    int          exp_n;
    logic [23:0] exp_chans;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [2:0] sel_now();
    return {bus.s2, bus.s1, bus.s0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},   {29'd0, sel_now()}, 0);
    check({tag, "_data"},  {29'd0, bus.out_data}, 0);
    check({tag, "_chan"},  {29'd0, bus.out_chan}, 0);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 0);
    check({tag, "_done"},  {31'd0, bus.done}, 0);
    check({tag, "_state"}, {30'd0, dbg_state}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int   edge_cnt;
    int   held;
    int   sample;
    logic fin;
    exp_q.delete();
    for (int i = 0; i < v.exp_n; i++) exp_q.push_back(v.exp_chans[3*i +: 3]);
    bus.chan_mask = v.mask;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edge_cnt = 0; held = 0; sample = 0; fin = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, (v.exp_n != 0) ? 1 : 0);
    if (v.exp_n != 0) check("sel_first", {29'd0, sel_now()}, {29'd0, v.exp_chans[2:0]});
    while (!fin) begin
      bus.start = v.mid_start && (edge_cnt == 2);
      if (v.mid_start && edge_cnt == 2) bus.chan_mask = 8'hFF;
      if (edge_cnt == 1 && v.exp_n != 0) check("valid_after_e1", {31'd0, bus.out_valid}, 1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_valid");
          bus.out_ready = 1'b1;
        end else begin
          check("out_chan", {29'd0, bus.out_chan}, {29'd0, exp_q[0]});
          check("out_data", {29'd0, bus.out_data}, {29'd0, exp_q[0]});
          check("sel_hold", {29'd0, sel_now()}, {29'd0, exp_q[0]});
          if (sample == 0 && held < v.stall) begin
            bus.out_ready = 1'b0;
            held++;
          end else begin
            bus.out_ready = 1'b1;
            void'(exp_q.pop_front());
            sample++;
          end
        end
      end
      if (bus.done) begin
        check("done_cycle", edge_cnt, v.exp_cycles);
        check("remaining_samples", exp_q.size(), 0);
        check("busy_at_done", {31'd0, bus.busy}, 0);
        fin = 1'b1;
      end else if (edge_cnt > 100) begin
        fail("scan_timeout");
        fin = 1'b1;
      end else begin
        if (v.exp_n != 0) check("busy_mid", {31'd0, bus.busy}, 1);
        @(posedge clk); #1;
        edge_cnt++;
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, bus.done}, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.chan_mask = 8'h00;
    bus.out_ready = 1'b1;

    vecs[0] = '{mask: 8'hFF,        stall: 0, mid_start: 1'b0, exp_n: 8, exp_chans: 24'o76543210, exp_cycles: 16};
    vecs[1] = '{mask: 8'b1010_0100, stall: 0, mid_start: 1'b0, exp_n: 3, exp_chans: 24'o752,      exp_cycles: 6};
    vecs[2] = '{mask: 8'h81,        stall: 5, mid_start: 1'b0, exp_n: 2, exp_chans: 24'o70,       exp_cycles: 9};
    vecs[3] = '{mask: 8'h00,        stall: 0, mid_start: 1'b0, exp_n: 0, exp_chans: 24'o0,        exp_cycles: 0};
    vecs[4] = '{mask: 8'b1010_0100, stall: 0, mid_start: 1'b1, exp_n: 3, exp_chans: 24'o752,      exp_cycles: 6};
    vecs[5] = '{mask: 8'h80,        stall: 2, mid_start: 1'b0, exp_n: 1, exp_chans: 24'o7,        exp_cycles: 4};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef MUX_SCAN_LOOP_EN
    begin
      int   seen;
      int   dones;
      logic [2:0] want;
      seen = 0; dones = 0; want = 3'd1;
      bus.chan_mask = 8'h06;
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int e = 0; e < 16; e++) begin
        if (bus.done) dones++;
        if (bus.out_valid) begin
          check("loop_chan", {29'd0, bus.out_chan}, {29'd0, want});
          check("loop_data", {29'd0, bus.out_data}, {29'd0, want});
          want = (want == 3'd1) ? 3'd2 : 3'd1;
          seen++;
        end
        @(posedge clk); #1;
      end
      check("loop_samples", seen, 8);
      check("loop_no_done", dones, 0);
      check("loop_busy", {31'd0, bus.busy}, 1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check("loop_abort_busy", {31'd0, bus.busy}, 0);
      check("loop_abort_valid", {31'd0, bus.out_valid}, 0);
      check("loop_abort_done", {31'd0, bus.done}, 0);
    end
`else
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort while holding the channel 3 sample of a full scan.
    bus.chan_mask = 8'hFF;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_pre_chan", {29'd0, bus.out_chan}, 3);
    check("abort_pre_valid", {31'd0, bus.out_valid}, 1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_valid", {31'd0, bus.out_valid}, 0);
    check("abort_busy", {31'd0, bus.busy}, 0);
    begin
      int dones;
      dones = 0;
      for (int e = 0; e < 20; e++) begin
        if (bus.done) dones++;
        @(posedge clk); #1;
      end
      check("abort_no_done", dones, 0);
    end

    // Start together with abort in IDLE must be refused.
    bus.chan_mask = 8'hFF;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", {31'd0, bus.busy}, 0);
    check("start_abort_done", {31'd0, bus.done}, 0);

    // Asynchronous reset in the middle of a held sample.
    bus.chan_mask = 8'hFF;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("prereset_chan", {29'd0, bus.out_chan}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[1]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Sequential channel scanner that sits directly upstream of, and drives the select lines of, the 3-bit 8:1 multiplexer (`_8_1mux`). On a start pulse it walks the enabled channels of an 8-bit mask in ascending order. For each enabled channel it drives `s2,s1,s0`, samples the multiplexer output one cycle later, and presents the sample with its channel index on a valid/ready output port.

## Interface
- `WIDTH`, default 3: data width of the multiplexer output and `out_data`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a scan. Sampled only in IDLE.
- `abort`  in  1  terminates any scan in progress.
- `chan_mask`  in  8  enabled channels, bit i = channel i. Latched at start.
- `mux_y`  in  WIDTH  output of the downstream 8:1 multiplexer.
- `s2`, `s1`, `s0`  out  1 each  multiplexer select. `{s2,s1,s0}` is the channel index.
- `out_data`  out  WIDTH  captured sample.
- `out_chan`  out  3  channel index of `out_data`.
- `out_valid`  out  1  sample available.
- `out_ready`  in  1  consumer accepts the sample.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a scan completes normally.

## Operation
- The FSM has three states: IDLE, SEL, HOLD.
- IDLE, `start`=1, latched mask ≠ 0: the FSM goes to SEL with the select lines set to the lowest set bit.
- IDLE, `start`=1, mask = 0: the FSM stays in IDLE and pulses `done` on the next cycle. No sample is produced.
- SEL: the select lines are stable for the whole cycle. At the next edge the block captures `mux_y` into `out_data` and the current index into `out_chan`, sets `out_valid`=1, and goes to HOLD.
- HOLD: `out_valid`, `out_data`, `out_chan` and the select lines all stay stable until `out_ready`=1 at a clock edge.
- On transfer, if a higher set mask bit remains, the FSM goes to SEL for that channel and clears `out_valid`.
- On transfer, if no higher set bit remains, the FSM goes to IDLE, pulses `done`, and clears `out_valid`.
- `abort`=1 at any edge outside IDLE: the FSM goes to IDLE, clears `out_valid`, and does not pulse `done`. `abort` takes priority over the handshake.
- `abort` together with `start` in IDLE: the FSM stays in IDLE.
- `start` outside IDLE is ignored.
- Changes to `chan_mask` during a scan are ignored.
- `rst_n` low at any time, including mid-scan: the FSM goes to IDLE immediately, and every output goes to 0, so select = 000.

## Timing
- Reset values: `s2`=`s1`=`s0`=0, `out_data`=0, `out_chan`=0, `out_valid`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0: select is valid after E0, `out_valid` rises after E1.
- Per channel: at least 2 cycles (SEL, then HOLD with immediate ready). Each cycle of withheld ready adds one cycle.
- `done` rises after the edge that accepts the last sample and is high for exactly one cycle.
- The earliest next `start` is sampled at the edge after `done`.
- Full scan of 8 channels with `out_ready` tied high: 16 cycles from E0 to the `done` edge.
- `mux_y` must settle within one cycle of a select change. The multiplexer is purely combinational.

## Configuration
- `MUX_SCAN_LOOP_EN` defined: after the last set channel is accepted, the scan wraps to the lowest set channel and continues indefinitely. `done` never pulses, and the scan ends only via `abort` or reset.
- `MUX_SCAN_LOOP_EN` not defined: a single pass per `start`, as described above.

## Test plan
Bench instantiates this block driving `_8_1mux`, with multiplexer inputs a..h = 3'd0..3'd7, so `mux_y` equals the channel index.
- Mask 8'hFF, ready tied high: 8 transfers with `out_chan`=`out_data`=0..7 on consecutive 2-cycle beats, then `done` for one cycle, 16 cycles after `start`.
- Mask 8'b1010_0100: transfers for channels 2, 5, 7 only, with `out_data`=2, 5, 7. `busy` drops together with `done`.
- Mask 8'h81, ready held low for 5 cycles on the first sample: `out_valid`, `out_data`=0 and select=000 stay stable for 5 cycles. Then channel 7 is transferred, then `done`.
- Mask 8'h00 with `start`: no `out_valid`, `done` pulses one cycle later. A `start` issued mid-scan is ignored, confirmed by the same transfer count.
- `abort` during HOLD on channel 3 of mask 8'hFF: `out_valid` is 0 and `busy` is 0 on the next cycle, no `done`. `rst_n` pulsed mid-scan: all outputs 0 asynchronously.
- With `MUX_SCAN_LOOP_EN`, mask 8'h06: repeated sequence 1, 2, 1, 2, … over more than 3 rounds, no `done`. `abort` stops the sequence.
